hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters: REG_NUM, 32, register count (index width $clog2(REG_NUM)); CNT_WIDTH, 32, perf counter width; TIMEOUT, 256, memory-wait cycles before error flag.
REQ-002 clk  in  1  rising-edge clock, single clock domain.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 id_valid, id_rs1_used, id_rs2_used  in  1 each  decode-stage instruction valid / source-operand usage.
REQ-005 id_rs1, id_rs2  in  $clog2(REG_NUM) each  decode-stage source registers.
REQ-006 ex_valid, ex_wr_reg_en, ex_is_load  in  1 each  EX-stage valid / writes rd / is load.
REQ-007 ex_rd  in  $clog2(REG_NUM)  EX-stage destination register.
REQ-008 branch_taken  in  1  EX-stage redirect, qualified by ex_valid.
REQ-009 mm_valid, mm_is_load, mm_mem_ready  in  1 each  MEM-stage valid / load / data-memory response ready.
REQ-010 stall_f, stall_d, stall_e, stall_m  out  1 each  hold PC, IF/ID, ID/EX, EX/MEM registers.
REQ-011 flush_d, flush_e, flush_w  out  1 each  bubble into IF/ID, ID/EX, MEM/WB.
REQ-012 mem_timeout  out  1  sticky memory-wait timeout flag.
REQ-013 stall_cycles  out  CNT_WIDTH  count of cycles with stall_f=1.

Function
REQ-014 Terms: mem_wait = mm_valid & mm_is_load & ~mm_mem_ready; redirect = ex_valid & branch_taken; load_use = id_valid & ex_valid & ex_is_load & ex_wr_reg_en & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
REQ-015 Control outputs are combinational from current inputs and the registered run flag; zero-cycle latency.
REQ-016 Priority: mem_wait > redirect > load_use > none.
REQ-017 mem_wait: stall_f=stall_d=stall_e=stall_m=1, flush_w=1, flush_d=flush_e=0.
REQ-018 redirect (no mem_wait): flush_d=flush_e=1, all stalls 0, flush_w=0; load_use ignored.
REQ-019 load_use only: stall_f=stall_d=1, flush_e=1, stall_e=stall_m=0, flush_d=flush_w=0.
REQ-020 None: all control outputs 0.
REQ-021 Register x0 (index 0) never produces a hazard.
REQ-022 FSM states RUN, WAIT; RUN->WAIT on clock edge where mem_wait=1; WAIT->RUN on edge where mem_wait=0; else hold.
REQ-023 wait_cnt (internal, >= $clog2(TIMEOUT)+1 bits) increments each cycle in WAIT with mem_wait=1, saturates, clears on edge returning to RUN.
REQ-024 mem_timeout sets on edge where wait_cnt==TIMEOUT-1 and mem_wait=1; remains 1 until reset; does not alter stall behaviour.
REQ-025 stall_cycles increments by 1 on each edge where stall_f=1; saturates at all-ones, no wrap.
REQ-026 branch_taken held during mem_wait takes effect in first cycle after mem_wait drops.

Reset
REQ-027 rst_n low: state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0, run flag=0, immediately (asynchronous).
REQ-028 Run flag sets on first rising clk with rst_n high; while 0, all control outputs are 0 regardless of inputs.
REQ-029 Reset asserted mid-WAIT aborts wait; after release, behaviour as from power-up.

Verification
REQ-030 Load-use: ex_rd=5 load, id_rs1=5 used -> one cycle stall_f=stall_d=flush_e=1; next cycle (load in MEM, ready=1) all outputs 0; stall_cycles=1.
REQ-031 x0: ex load rd=0, id_rs1=0 used -> no stall/flush.
REQ-032 Memory wait: mm load with mm_mem_ready=0 for 3 cycles -> stall_f/d/e/m=flush_w=1 for 3 cycles, state WAIT, stall_cycles=3, then RUN on ready.
REQ-033 Priority: redirect + load_use same cycle -> flush_d=flush_e=1, stall_f=0; add mem_wait -> mem_wait pattern only.
REQ-034 Timeout: TIMEOUT=4, ready held 0 for 6 cycles -> mem_timeout=1 after 4th wait edge, stays 1 after ready returns, clears only on rst_n.
REQ-035 Reset mid-wait: rst_n low during WAIT -> outputs 0 immediately, counters 0; after release first cycle outputs 0 even with mem_wait=1, normal thereafter.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: resolves memory-wait, branch-redirect and load-use
// hazards into stall/flush controls, with a sticky memory timeout and a stall counter.
module hazard_ctrl #(
    parameter int REG_NUM   = 32,
    parameter int CNT_WIDTH = 32,
    parameter int TIMEOUT   = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       id_valid,
    input  logic                       id_rs1_used,
    input  logic                       id_rs2_used,
    input  logic [$clog2(REG_NUM)-1:0] id_rs1,
    input  logic [$clog2(REG_NUM)-1:0] id_rs2,
    input  logic                       ex_valid,
    input  logic                       ex_wr_reg_en,
    input  logic                       ex_is_load,
    input  logic [$clog2(REG_NUM)-1:0] ex_rd,
    input  logic                       branch_taken,
    input  logic                       mm_valid,
    input  logic                       mm_is_load,
    input  logic                       mm_mem_ready,
    output logic                       stall_f,
    output logic                       stall_d,
    output logic                       stall_e,
    output logic                       stall_m,
    output logic                       flush_d,
    output logic                       flush_e,
    output logic                       flush_w,
    output logic                       mem_timeout,
    output logic [CNT_WIDTH-1:0]       stall_cycles
);

    localparam int WCNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    typedef enum logic {RUN, WAIT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              run;
    logic [WCNT_W-1:0] wait_cnt;
    logic              mem_wait;
    logic              redirect;
    logic              load_use;
    logic              rs1_hit;
    logic              rs2_hit;

    // Hazard terms are gated by the run flag so the first cycle out of reset is quiet.
    always_comb begin
        rs1_hit  = id_rs1_used && (id_rs1 == ex_rd);
        rs2_hit  = id_rs2_used && (id_rs2 == ex_rd);
        mem_wait = run && mm_valid && mm_is_load && !mm_mem_ready;
        redirect = run && ex_valid && branch_taken;
        load_use = run && id_valid && ex_valid && ex_is_load && ex_wr_reg_en &&
                   (ex_rd != '0) && (rs1_hit || rs2_hit);
    end

    always_comb begin
        state_nxt = state;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        stall_m   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        flush_w   = 1'b0;
        case (state)
            RUN:     if (mem_wait)  state_nxt = WAIT;
            WAIT:    if (!mem_wait) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
        if (mem_wait) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (redirect) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            run   <= 1'b0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
        end
    end

    // wait_cnt only advances while already parked in WAIT; it resets on leaving WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            if (state == WAIT) begin
                if (!mem_wait)
                    wait_cnt <= '0;
                else if (wait_cnt != '1)
                    wait_cnt <= wait_cnt + WCNT_W'(1);
            end
            if (mem_wait && (wait_cnt == WCNT_LAST))
                mem_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (stall_f && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_WIDTH'(1);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected values are queued as each step is driven
// and popped against the DUT outputs (controls before the edge, counters after it).
module tb_hazard_ctrl;

    localparam int REG_NUM   = 32;
    localparam int CNT_WIDTH = 4;
    localparam int TIMEOUT   = 4;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100010;
    localparam logic [6:0] C_RD   = 7'b0000110;
    localparam logic [6:0] C_MW   = 7'b1111001;

    logic clk;
    logic rst_n;
    logic id_valid, id_rs1_used, id_rs2_used;
    logic [4:0] id_rs1, id_rs2;
    logic ex_valid, ex_wr_reg_en, ex_is_load;
    logic [4:0] ex_rd;
    logic branch_taken;
    logic mm_valid, mm_is_load, mm_mem_ready;
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_w;
    logic mem_timeout;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic [6:0] ctrl;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];

    hazard_ctrl #(.REG_NUM(REG_NUM), .CNT_WIDTH(CNT_WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_valid(ex_valid), .ex_wr_reg_en(ex_wr_reg_en), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .branch_taken(branch_taken),
        .mm_valid(mm_valid), .mm_is_load(mm_is_load), .mm_mem_ready(mm_mem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    assign ctrl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic sb_push(input string tag, input int kind, input logic [31:0] v);
        sbq.push_back('{tag, kind, v});
    endtask

    task automatic sb_check();
        sb_t e;
        logic [31:0] obs;
        n_tests++;
        if (sbq.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty: observed empty queue, expected an entry");
            return;
        end
        e = sbq.pop_front();
        case (e.kind)
            0:       obs = {25'b0, ctrl};
            1:       obs = 32'(stall_cycles);
            default: obs = {31'b0, mem_timeout};
        endcase
        assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
        end
    endtask

    task automatic clr();
        id_valid = 0; id_rs1_used = 0; id_rs2_used = 0; id_rs1 = 0; id_rs2 = 0;
        ex_valid = 0; ex_wr_reg_en = 0; ex_is_load = 0; ex_rd = 0; branch_taken = 0;
        mm_valid = 0; mm_is_load = 0; mm_mem_ready = 1;
    endtask

    task automatic mem_wait_in(input logic rdy);
        mm_valid = 1; mm_is_load = 1; mm_mem_ready = rdy;
    endtask

    task automatic load_in_ex(input logic [4:0] rd);
        ex_valid = 1; ex_wr_reg_en = 1; ex_is_load = 1; ex_rd = rd;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step(input string tag, input logic [6:0] ec, input int ecnt, input logic eto);
        sb_push({tag, "_ctrl"}, 0, {25'b0, ec});
        #1 sb_check();
        @(posedge clk);
        #1;
        sb_push({tag, "_cnt"}, 1, 32'(ecnt));
        sb_push({tag, "_to"}, 2, {31'b0, eto});
        sb_check();
        sb_check();
        @(negedge clk);
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        mem_wait_in(1'b0);
        #1;
        sb_push("rst_ctrl", 0, 32'(C_NONE));
        sb_push("rst_cnt", 1, 32'd0);
        sb_push("rst_to", 2, 32'd0);
        sb_check(); sb_check(); sb_check();
        @(negedge clk);
        @(negedge clk);

        rst_n = 1'b1;
        step("pwr_first", C_NONE, 0, 0);

        clr(); load_in_ex(5); id_valid = 1; id_rs1_used = 1; id_rs1 = 5;
        step("lu_rs1", C_LU, 1, 0);
        clr(); id_valid = 1; id_rs1_used = 1; id_rs1 = 5; mem_wait_in(1'b1);
        step("lu_mem_ready", C_NONE, 1, 0);
        clr(); load_in_ex(7); id_valid = 1; id_rs2_used = 1; id_rs2 = 7;
        step("lu_rs2", C_LU, 2, 0);
        ex_is_load = 0;
        step("not_load", C_NONE, 2, 0);
        clr(); load_in_ex(0); id_valid = 1; id_rs1_used = 1; id_rs2_used = 1;
        step("x0", C_NONE, 2, 0);
        clr(); load_in_ex(5); id_valid = 1; id_rs1 = 5;
        step("rs1_unused", C_NONE, 2, 0);

        clr(); mem_wait_in(1'b0); ex_valid = 1; branch_taken = 1;
        step("mw_1", C_MW, 3, 0);
        step("mw_2", C_MW, 4, 0);
        step("mw_3", C_MW, 5, 0);
        mm_mem_ready = 1;
        step("mw_done_br", C_RD, 5, 0);

        clr(); load_in_ex(9); branch_taken = 1; id_valid = 1; id_rs1_used = 1; id_rs1 = 9;
        step("rd_lu", C_RD, 5, 0);
        mem_wait_in(1'b0);
        step("rd_lu_mw", C_MW, 6, 0);
        mm_mem_ready = 1;
        step("rd_lu_rdy", C_RD, 6, 0);

        clr(); mem_wait_in(1'b0);
        step("to_1", C_MW, 7, 0);
        step("to_2", C_MW, 8, 0);
        step("to_3", C_MW, 9, 0);
        step("to_4", C_MW, 10, 0);
        step("to_5", C_MW, 11, 1);
        step("to_6", C_MW, 12, 1);
        mm_mem_ready = 1;
        step("to_sticky", C_NONE, 12, 1);

        mm_mem_ready = 0;
        step("sat_1", C_MW, 13, 1);
        step("sat_2", C_MW, 14, 1);
        step("sat_3", C_MW, 15, 1);
        step("sat_4", C_MW, 15, 1);
        mm_mem_ready = 1;
        step("sat_rdy", C_NONE, 15, 1);

        mm_mem_ready = 0;
        step("mid_enter", C_MW, 15, 1);
        rst_n = 1'b0;
        #1;
        sb_push("mid_rst_cnt", 1, 32'd0);
        sb_push("mid_rst_to", 2, 32'd0);
        sb_check(); sb_check();
        step("mid_rst", C_NONE, 0, 0);
        rst_n = 1'b1;
        step("mid_release", C_NONE, 0, 0);
        step("mid_after", C_MW, 1, 0);
        mm_mem_ready = 1;
        step("mid_rdy", C_NONE, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
